uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Serial receive half of the UART; pairs with the existing transmitter and shares its frame configuration inputs.
- Oversamples rxd on a 16x sample tick from the shared baud generator and recovers start, data, optional parity and stop bits.
- Presents each received character on a valid/ready holding register with parity, framing and overrun status.

Parameters:
- OVERSAMPLE, 16, sample_tick pulses per bit period; even, at least 8.
- SYNC_STAGES, 2, rxd synchronizer depth; at least 2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- enable  input  1  UART global enable
- rx_enable  input  1  receiver enable
- parity_enable  input  1  parity bit present in frame
- parity_odd  input  1  1 = odd parity, 0 = even parity
- data_len_7bit  input  1  1 = 7 data bits, 0 = 8 data bits
- stop_2  input  1  two stop bits expected
- sample_tick  input  1  single-cycle pulse at OVERSAMPLE x baud
- rxd  input  1  asynchronous serial input, idle high
- data_out  output  8  received character; bit 7 is 0 in 7-bit mode
- data_valid  output  1  holding register full
- data_ready  input  1  consumer accepts data_out when data_valid is high
- parity_err  output  1  parity mismatch for the held character
- frame_err  output  1  stop bit sampled low for the held character
- overrun_err  output  1  one-cycle pulse when a character is dropped
- busy  output  1  state is not IDLE

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE, synchronizer chain all 1, counters 0, data_out 0, data_valid 0, parity_err 0, frame_err 0, overrun_err 0, busy 0.
- rxd passes through a SYNC_STAGES-deep flop chain. All sampling uses the synchronized value (rxs).
- If enable or rx_enable is low: state IDLE, tick counter and bit index cleared, data_valid and error flags cleared. Any frame in progress is discarded.
- The tick counter advances only on sample_tick. Mid-bit is tick count OVERSAMPLE/2-1 in START and OVERSAMPLE-1 in every later bit.
- IDLE: when rxs is low (falling edge), clear the counter and go to START.
- START: at mid-bit, if rxs is still low, go to DATA with bit index 0. If rxs is high, treat it as a false start and return to IDLE.
- DATA: at each mid-bit, shift the sampled bit in LSB first. After bit 6 (7-bit mode) or bit 7 (8-bit mode), go to PARITY if parity_enable is set, else STOP1. In 7-bit mode, bit 7 of the result is zero-filled.
- PARITY: at mid-bit, compute the XOR of the received data bits and the parity bit. A result of 1 with parity_odd=0, or 0 with parity_odd=1, is a parity error. Go to STOP1.
- STOP1: at mid-bit, a low sample is a framing error. If stop_2 is set, go to STOP2. Otherwise commit and go to IDLE at that mid-bit, half a bit early so the receiver resynchronizes on the next start edge.
- STOP2: at mid-bit, a low sample also sets the framing error. Commit and go to IDLE.
- Commit, when data_valid is 0 or data_ready is 1 in the same cycle: on the next cycle, data_out, parity_err and frame_err are loaded and data_valid is 1.
- Commit, when data_valid is 1 and data_ready is 0: the new character and its flags are dropped, the held data is unchanged, and overrun_err pulses for one cycle.
- Handshake: data_valid clears on the cycle after data_valid and data_ready are both high, unless a commit reloads the register in that same cycle. parity_err and frame_err are held with data_out and cleared when it is consumed.
- Latency: data_valid rises 1 clk after the final stop-bit mid-sample.
- Configuration inputs are sampled live and must be static while busy is 1.

Optional Feature:
- UART_RX_MAJORITY_EN defined: each bit value is the 2-of-3 majority of rxs taken at mid-bit-1, mid-bit and mid-bit+1 ticks. This applies to the START check as well.
- Not defined: a single rxs sample at the mid-bit tick. No vote registers are built.

Test Plan:
- 8N1, 0xA5 sent at 16x sample_tick, data_ready=1 -> data_valid pulses once, data_out=0xA5, parity_err=0, frame_err=0.
- 7E1 (parity_enable=1, parity_odd=0), 0x55 sent with parity bit 1 -> data_out=0x55, parity_err=1. Resend with parity bit 0 -> parity_err=0.
- 8N2, 0x3C sent with second stop bit forced low -> data_out=0x3C, frame_err=1. Next frame 0x3C sent clean -> frame_err=0.
- Low glitch on rxd shorter than 6 sample ticks while idle -> stays IDLE, busy returns to 0, data_valid stays 0.
- data_ready=0, two frames 0x11 then 0x22 -> data_out=0x11 held, overrun_err single pulse at the second stop mid-bit, and raising data_ready drains 0x11 only.
- rx_enable dropped mid-DATA, then a clean frame 0x81 -> partial frame discarded, next data_out=0x81. rst_n low mid-frame -> all outputs at reset values on the next clk edge.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: oversampled UART receiver feeding a valid/ready holding register.
// Define UART_RX_MAJORITY_EN for a 2-of-3 vote around each mid-bit tick.
module uart_rx #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       rx_enable,
  input  logic       parity_enable,
  input  logic       parity_odd,
  input  logic       data_len_7bit,
  input  logic       stop_2,
  input  logic       sample_tick,
  input  logic       rxd,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun_err,
  output logic       busy
);

  // state  | meaning
  // IDLE   | line idle, waiting for a low rxs
  // START  | qualifying the start bit at its mid point
  // DATA   | shifting data bits in, LSB first
  // PARITY | checking the parity bit
  // STOP1  | first stop bit; commits unless two stop bits are expected
  // STOP2  | second stop bit, then commit
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
  } state_t;

  localparam int CW = $clog2(OVERSAMPLE);

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_tick;
  logic [2:0]             r_bit;
  logic [7:0]             r_shift;
  logic                   r_par_acc;
  logic                   r_pe_acc;
  logic                   r_fe_acc;
  logic [7:0]             r_data;
  logic                   r_valid;
  logic                   r_perr;
  logic                   r_ferr;
  logic                   r_overrun;

  logic                   w_rxs;
  logic                   w_bit;
  logic [CW-1:0]          w_dec_cnt;
  logic                   w_at_dec;
  logic [2:0]             w_last_bit;
  logic                   w_fe_now;
  logic [7:0]             w_char;
  logic                   w_can_load;

  assign w_rxs = r_sync[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_EN
  // Decision lands on the tick after mid-bit so all three samples exist.
  localparam logic [CW-1:0] START_DEC = CW'(OVERSAMPLE/2);
  localparam logic [CW-1:0] BIT_DEC   = CW'(OVERSAMPLE-1);
  logic [1:0] r_vote;

  assign w_dec_cnt = (r_state == S_START) ? START_DEC : BIT_DEC;
  assign w_bit = (r_vote[0] & r_vote[1]) | (r_vote[0] & w_rxs) | (r_vote[1] & w_rxs);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vote <= 2'b11;
    end else if (sample_tick) begin
      if (r_tick == w_dec_cnt - CW'(2)) r_vote[0] <= w_rxs;
      if (r_tick == w_dec_cnt - CW'(1)) r_vote[1] <= w_rxs;
    end
  end
`else
  localparam logic [CW-1:0] START_MID = CW'(OVERSAMPLE/2 - 1);
  localparam logic [CW-1:0] BIT_MID   = CW'(OVERSAMPLE - 1);

  assign w_dec_cnt = (r_state == S_START) ? START_MID : BIT_MID;
  assign w_bit     = w_rxs;
`endif

  assign w_at_dec   = sample_tick && (r_tick == w_dec_cnt);
  assign w_last_bit = data_len_7bit ? 3'd6 : 3'd7;
  assign w_fe_now   = r_fe_acc | ~w_bit;
  assign w_char     = data_len_7bit ? {1'b0, r_shift[7:1]} : r_shift;
  assign w_can_load = !r_valid || data_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], rxd};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_tick    <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_par_acc <= 1'b0;
      r_pe_acc  <= 1'b0;
      r_fe_acc  <= 1'b0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (r_valid && data_ready) begin
        r_valid <= 1'b0;
        r_perr  <= 1'b0;
        r_ferr  <= 1'b0;
      end
      if (!enable || !rx_enable) begin
        r_state <= S_IDLE;
        r_tick  <= '0;
        r_bit   <= '0;
        r_valid <= 1'b0;
        r_perr  <= 1'b0;
        r_ferr  <= 1'b0;
      end else begin
        if (sample_tick && r_state != S_IDLE)
          r_tick <= w_at_dec ? '0 : r_tick + 1'b1;
        case (r_state)
          S_IDLE: begin
            if (!w_rxs) begin
              r_tick  <= '0;
              r_state <= S_START;
            end
          end
          S_START: begin
            if (w_at_dec) begin
              if (!w_bit) begin
                r_state   <= S_DATA;
                r_bit     <= '0;
                r_shift   <= '0;
                r_par_acc <= 1'b0;
                r_pe_acc  <= 1'b0;
                r_fe_acc  <= 1'b0;
              end else begin
                r_state <= S_IDLE;
              end
            end
          end
          S_DATA: begin
            if (w_at_dec) begin
              r_shift   <= {w_bit, r_shift[7:1]};
              r_par_acc <= r_par_acc ^ w_bit;
              r_bit     <= r_bit + 1'b1;
              if (r_bit == w_last_bit)
                r_state <= parity_enable ? S_PARITY : S_STOP1;
            end
          end
          S_PARITY: begin
            if (w_at_dec) begin
              r_pe_acc <= r_par_acc ^ w_bit ^ parity_odd;
              r_state  <= S_STOP1;
            end
          end
          S_STOP1, S_STOP2: begin
            if (w_at_dec) begin
              if (r_state == S_STOP1 && stop_2) begin
                r_fe_acc <= w_fe_now;
                r_state  <= S_STOP2;
              end else begin
                r_state <= S_IDLE;
                if (w_can_load) begin
                  r_data  <= w_char;
                  r_perr  <= r_pe_acc;
                  r_ferr  <= w_fe_now;
                  r_valid <= 1'b1;
                end else begin
                  r_overrun <= 1'b1;
                end
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign data_out    = r_data;
  assign data_valid  = r_valid;
  assign parity_err  = r_perr;
  assign frame_err   = r_ferr;
  assign overrun_err = r_overrun;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives serial frames at 16x sample_tick and checks received
// characters against an expected-character queue built from the frame rules.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b1;
  logic       rx_enable = 1'b1;
  logic       parity_enable = 1'b0;
  logic       parity_odd = 1'b0;
  logic       data_len_7bit = 1'b0;
  logic       stop_2 = 1'b0;
  logic       sample_tick = 1'b0;
  logic       rxd = 1'b1;
  logic       data_ready = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic       overrun_err;
  logic       busy;

  uart_rx #(.OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .rx_enable(rx_enable),
    .parity_enable(parity_enable), .parity_odd(parity_odd),
    .data_len_7bit(data_len_7bit), .stop_2(stop_2), .sample_tick(sample_tick),
    .rxd(rxd), .data_out(data_out), .data_valid(data_valid),
    .data_ready(data_ready), .parity_err(parity_err), .frame_err(frame_err),
    .overrun_err(overrun_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int div = 0;
  always @(posedge clk) begin
    div         <= (div == 3) ? 0 : div + 1;
    sample_tick <= (div == 3);
  end

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_acc = 0;
  int   ov_cycles = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Consumer side: every accepted character must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && overrun_err) ov_cycles++;
    if (rst_n && data_valid && data_ready) begin
      n_acc++;
      if (q.size() == 0) begin
        check("unexpected_char_count", 32'(n_acc), 32'(n_acc - 1));
      end else begin
        m_e = q.pop_front();
        check("rx_data", 32'(data_out), 32'(m_e.d));
        check("rx_parity_err", 32'(parity_err), 32'(m_e.pe));
        check("rx_frame_err", 32'(frame_err), 32'(m_e.fe));
      end
    end
  end

  task automatic wait_ticks(input int n);
    int c = 0;
    while (c < n) begin
      @(posedge clk);
      if (sample_tick) c++;
    end
  endtask

  task automatic send_bit(input logic b, input int n);
    @(negedge clk);
    rxd = b;
    wait_ticks(n);
  endtask

  // Low stop bit is released early so the tail cannot pass as a real start.
  task automatic send_stop(input logic bad);
    if (bad) begin
      send_bit(1'b0, 12);
      send_bit(1'b1, 4);
    end else begin
      send_bit(1'b1, 16);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic len7, input logic pen,
                            input logic podd, input logic pbit, input logic s2,
                            input logic bad1, input logic bad2, input logic push);
    exp_t e;
    int   nbits;
    logic [7:0] dm;
    nbits = len7 ? 7 : 8;
    dm    = len7 ? (d & 8'h7F) : d;
    @(negedge clk);
    parity_enable = pen;
    parity_odd    = podd;
    data_len_7bit = len7;
    stop_2        = s2;
    e.d  = dm;
    e.pe = pen && ((($countones(dm) + int'(pbit)) % 2) != int'(podd));
    e.fe = bad1 || (s2 && bad2);
    if (push) q.push_back(e);
    send_bit(1'b0, 16);
    for (int i = 0; i < nbits; i++) send_bit(d[i], 16);
    if (pen) send_bit(pbit, 16);
    send_stop(bad1);
    if (s2) send_stop(bad2);
    send_bit(1'b1, 6);
  endtask

  int acc0;
  int ov0;

  initial begin
    repeat (5) @(negedge clk);
    check("reset_data_out", 32'(data_out), 32'h0);
    check("reset_data_valid", 32'(data_valid), 32'h0);
    check("reset_parity_err", 32'(parity_err), 32'h0);
    check("reset_frame_err", 32'(frame_err), 32'h0);
    check("reset_overrun", 32'(overrun_err), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    wait_ticks(8);

    // 8N1 0xA5
    acc0 = n_acc;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("8n1_accept_once", 32'(n_acc - acc0), 32'd1);
    check("8n1_busy_idle", 32'(busy), 32'h0);

    // 7E1 0x55, wrong then right parity bit
    acc0 = n_acc;
    send_frame(8'h55, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'h55, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("7e1_accept", 32'(n_acc - acc0), 32'd2);

    // 8N2 0x3C, second stop low then clean
    acc0 = n_acc;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("8n2_accept", 32'(n_acc - acc0), 32'd2);

    // short low glitch while idle
    @(negedge clk);
    stop_2 = 1'b0;
    acc0 = n_acc;
    send_bit(1'b0, 4);
    @(negedge clk);
    check("glitch_busy_seen", 32'(busy), 32'h1);
    rxd = 1'b1;
    wait_ticks(32);
    @(negedge clk);
    check("glitch_busy_back", 32'(busy), 32'h0);
    check("glitch_no_valid", 32'(data_valid), 32'h0);
    check("glitch_no_accept", 32'(n_acc - acc0), 32'd0);

    // overrun: consumer stalled across two frames
    @(negedge clk);
    data_ready = 1'b0;
    ov0  = ov_cycles;
    acc0 = n_acc;
    send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("ovr_no_pulse_first", 32'(ov_cycles - ov0), 32'd0);
    send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ovr_single_pulse", 32'(ov_cycles - ov0), 32'd1);
    check("ovr_held_valid", 32'(data_valid), 32'h1);
    check("ovr_held_data", 32'(data_out), 32'h11);
    @(negedge clk);
    data_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("ovr_drain_one", 32'(n_acc - acc0), 32'd1);
    check("ovr_drained_valid", 32'(data_valid), 32'h0);

    // rx_enable dropped mid-DATA, then a clean frame
    acc0 = n_acc;
    send_bit(1'b0, 16);
    send_bit(1'b1, 16);
    send_bit(1'b0, 16);
    @(negedge clk);
    check("en_busy_mid", 32'(busy), 32'h1);
    rx_enable = 1'b0;
    rxd = 1'b1;
    repeat (2) @(negedge clk);
    check("en_busy_off", 32'(busy), 32'h0);
    wait_ticks(20);
    @(negedge clk);
    rx_enable = 1'b1;
    wait_ticks(4);
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("en_accept_clean", 32'(n_acc - acc0), 32'd1);

    // randomized frames and configurations
    acc0 = n_acc;
    for (int i = 0; i < 10; i++) begin
      send_frame(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), 1'b1);
    end
    check("rand_accept", 32'(n_acc - acc0), 32'd10);
    check("rand_queue_empty", 32'(q.size()), 32'd0);

    // reset in the middle of a frame with a character held
    @(negedge clk);
    data_ready = 1'b0;
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_pre_valid", 32'(data_valid), 32'h1);
    send_bit(1'b0, 16);
    send_bit(1'b1, 16);
    @(negedge clk);
    check("rst_pre_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    q.delete();
    @(negedge clk);
    check("rst_data_out", 32'(data_out), 32'h0);
    check("rst_data_valid", 32'(data_valid), 32'h0);
    check("rst_parity_err", 32'(parity_err), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    check("rst_overrun", 32'(overrun_err), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rxd = 1'b1;
    data_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_ticks(8);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("final_queue_empty", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
